// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the board-level ALU front-end.
//   - default operand/opcode widths
//   - button and flag bit indices
//   - opcode encodings
package alu_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  // Button roles on i_btn
  localparam int NB_BTN = 3;
  localparam int BTN_A  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 2;

  // Flag register bit positions
  localparam int NB_FLAGS   = 3;
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;

  // Opcodes
  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions one raw push-button.
//   2-FF synchroniser -> debouncer -> registered rising-edge pulse.
// Ports:
//   clk      system clock
//   i_rst_n  asynchronous active-low reset
//   i_btn    raw, asynchronous, bouncy button level
//   o_press  one-cycle pulse per accepted press (release produces nothing)
module btn_conditioner #(
  parameter int DB_CYCLES = 1000000,
  parameter int NB_DB_CNT = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [NB_DB_CNT-1:0] CNT_LAST = NB_DB_CNT'(DB_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  logic                 level_q, level_d;
  logic                 level_dly_q;
  logic                 press_q, press_d;
  logic [NB_DB_CNT-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised level disagrees with the
  // accepted level; any agreement restarts it, so short bounces never win.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= i_btn;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/alu_btn_ctrl.sv
// alu_btn_ctrl: button/switch front-end plus registered ALU.
//   Each button is conditioned; a press latches the shared switches into
//   A (btn0), B (btn1) or OP (btn2). Any latch recomputes the result and
//   flags on the following edge, with a one-cycle o_valid strobe.
// Ports:
//   clk        system clock
//   i_rst_n    asynchronous active-low reset
//   i_btn      raw buttons [0]=load A, [1]=load B, [2]=load op
//   i_sw_op    opcode switches
//   i_sw_data  data switches, shared by A and B
//   o_result   registered result
//   o_zero     result == 0
//   o_carry    ADD carry / SUB borrow
//   o_ovf      ADD/SUB signed overflow
//   o_valid    one-cycle pulse when result/flags update
module alu_btn_ctrl
  import alu_pkg::*;
#(
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NB_OP     = NB_OP_DEF,
  parameter int DB_CYCLES = 1000000,
  parameter int NB_DB_CNT = $clog2(DB_CYCLES)
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_BTN-1:0]  i_btn,
  input  logic [NB_OP-1:0]   i_sw_op,
  input  logic [NB_DATA-1:0] i_sw_data,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_ovf,
  output logic               o_valid
);

  localparam logic [NB_DATA-1:0] SH_LIMIT = NB_DATA'(NB_DATA);

  logic [NB_BTN-1:0]   press;
  logic [NB_DATA-1:0]  a_q, b_q;
  logic [NB_OP-1:0]    op_q;
  logic                upd_q;
  logic                valid_q;
  logic [NB_DATA-1:0]  res_q, res_d;
  logic [NB_FLAGS-1:0] flags_q, flags_d;
  logic [NB_DATA:0]    sum, diff;

  for (genvar g = 0; g < NB_BTN; g++) begin : g_btn
    btn_conditioner #(
      .DB_CYCLES (DB_CYCLES),
      .NB_DB_CNT (NB_DB_CNT)
    ) u_btn (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_btn   (i_btn[g]),
      .o_press (press[g])
    );
  end

  always_comb begin
    res_d   = '0;
    flags_d = '0;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    case (op_q)
      OP_ADD: begin
        res_d               = sum[NB_DATA-1:0];
        flags_d[FLAG_CARRY] = sum[NB_DATA];
        flags_d[FLAG_OVF]   = (a_q[NB_DATA-1] == b_q[NB_DATA-1]) &&
                              (sum[NB_DATA-1] != a_q[NB_DATA-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow (A < B).
        res_d               = diff[NB_DATA-1:0];
        flags_d[FLAG_CARRY] = diff[NB_DATA];
        flags_d[FLAG_OVF]   = (a_q[NB_DATA-1] != b_q[NB_DATA-1]) &&
                              (diff[NB_DATA-1] != a_q[NB_DATA-1]);
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_XOR: res_d = a_q ^ b_q;
      OP_NOR: res_d = ~(a_q | b_q);
      OP_SRA: begin
        if (b_q >= SH_LIMIT) begin
          res_d = {NB_DATA{a_q[NB_DATA-1]}};
        end else begin
          res_d = $signed(a_q) >>> b_q;
        end
      end
      OP_SRL: begin
        if (b_q >= SH_LIMIT) begin
          res_d = '0;
        end else begin
          res_d = a_q >> b_q;
        end
      end
      default: res_d = '0;
    endcase
    flags_d[FLAG_ZERO] = (res_d == '0);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      upd_q   <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      if (press[BTN_A])  a_q  <= i_sw_data;
      if (press[BTN_B])  b_q  <= i_sw_data;
      if (press[BTN_OP]) op_q <= i_sw_op;
      upd_q   <= |press;
      valid_q <= upd_q;
      if (upd_q) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

  assign o_result = res_q;
  assign o_zero   = flags_q[FLAG_ZERO];
  assign o_carry  = flags_q[FLAG_CARRY];
  assign o_ovf    = flags_q[FLAG_OVF];
  assign o_valid  = valid_q;

endmodule

// File: doc/alu_btn_ctrl.md
# alu_btn_ctrl

Parametrised front-end plus ALU for the board-level ALU design: conditions N push-buttons (synchronise, debounce, rising-edge detect) and latches operand A, operand B and the opcode from shared switches. Computes a registered result with zero/carry/overflow flags and a one-cycle valid strobe. Sits between board I/O (buttons, switches) and LEDs/downstream logic.

## Interface
- NB_DATA, 8, operand/result width (≥ 4)
- NB_OP, 6, opcode width
- DB_CYCLES, 1000000, cycles a synchronised button level must be stable before acceptance (≥ 2); benches override to 4
- NB_DB_CNT, $clog2(DB_CYCLES), debounce counter width
- clk  in  1  system clock; single clock domain
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_btn  in  3  raw buttons: [0] load A, [1] load B, [2] load op; asynchronous, bouncy
- i_sw_op  in  NB_OP  opcode switches
- i_sw_data  in  NB_DATA  data switches, shared by A and B
- o_result  out  NB_DATA  registered signed result
- o_zero  out  1  result == 0
- o_carry  out  1  unsigned carry (ADD) / borrow (SUB), else 0
- o_ovf  out  1  signed overflow (ADD/SUB), else 0
- o_valid  out  1  one-cycle pulse when result/flags update

## Operation
- Per button: 2-FF synchroniser -> debouncer -> rising-edge pulse. Debouncer: counter increments each cycle the synchronised level differs from the accepted level, clears when equal; on reaching DB_CYCLES-1 while still different, accepted level takes the new value, counter clears.
- Press pulse = accepted rose this cycle. Only rising edges act; release does nothing.
- Pulse[0] latches i_sw_data into A, pulse[1] into B, pulse[2] i_sw_op into OP. Buttons independent: simultaneous pulses all latch in the same cycle (no priority).
- Any latch event triggers a result update on the following edge from the new A/B/OP; o_valid pulses with it.
- Ops (others -> result 0, flags carry/ovf 0, zero 1): ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
- ADD/SUB: NB_DATA+1-bit unsigned sum; carry = bit NB_DATA (SUB: carry = borrow = A<B unsigned). ovf = operand signs agree (ADD) / differ (SUB) and result sign differs from A.
- Shifts: amount = B unsigned; B ≥ NB_DATA -> SRL gives 0, SRA gives all sign bits.
- Bounces shorter than DB_CYCLES never change accepted level; a held button produces exactly one press.

## Timing
- Reset: A, B, OP, o_result, flags, o_valid, accepted levels, counters, synchronisers all 0 (o_zero resets to 0 too — flags only meaningful after first o_valid).
- Latency: raw button stable high from edge 0 -> operand register updated at edge DB_CYCLES+3 -> o_result/flags update and o_valid high in the cycle after edge DB_CYCLES+4.
- Switches sampled on the latch edge only; later switch changes have no effect until next press.
- Two latch events in consecutive cycles give two o_valid pulses; result reflects latest registers.
- Reset mid-debounce abandons the count; a button held across reset release is accepted as a fresh press after the full latency.

## Structure
- Package alu_pkg: opcode localparams, NB_DATA/NB_OP defaults, flag bit indices.
- Sub-module btn_conditioner (sync + debounce + edge, parameter DB_CYCLES), instantiated per button via generate. ALU function and flag logic inline in alu_btn_ctrl.

## Test plan (DB_CYCLES = 4)
- Reset: assert i_rst_n=0 mid-run -> all outputs 0 immediately; no o_valid until a press.
- Press A with sw=0x7F, B with 0x01, op with 100000 -> o_result 0x80, o_ovf 1, o_carry 0, o_zero 0; o_valid exactly 3 single pulses; latency DB_CYCLES+4 checked on first press.
- SUB A=0x05, B=0x05 -> 0x00, o_zero 1, o_carry 0; then B=0x06 -> 0xFF, o_carry 1, o_ovf 0.
- Bounce: i_btn[0] toggles every 2 cycles for 20 cycles then stable high 10 cycles -> exactly one A latch, switch value at acceptance.
- Simultaneous btn[0]&btn[1] with sw=0x0C, op SRA, then B=9 -> A=B=0x0C result 0x00; A=0x80, SRA by 9 -> 0xFF.
- Unknown op 111111 -> result 0x00, o_zero 1, carry/ovf 0; held button 50 cycles -> one o_valid.
